// File: rtl/response_uart_tx_if.sv
// Response handshake between the control FSM and the response UART transmitter.
// Master presents a 2-byte response with send_request; slave accepts while ready is high.
interface response_uart_tx_if;
  logic       send_request;
  logic [7:0] response_code;
  logic [7:0] response_data;
  logic       ready;

  modport master (
    output send_request,
    output response_code,
    output response_data,
    input  ready
  );

  modport slave (
    input  send_request,
    input  response_code,
    input  response_data,
    output ready
  );
endinterface

// File: rtl/response_uart_tx.sv
// Serializes a 2-byte response (code, then data) as two back-to-back UART 8N1 frames.
// All outputs are registered from next-state so the serial line is glitch-free.
module response_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned CNT_W        = 13
) (
  input  logic               clock,
  input  logic               reset_n,
  response_uart_tx_if.slave  req,
  output logic               tx_serial,
  output logic               transmission_active,
  output logic               tx_done
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(CLKS_PER_BIT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             byte_idx_q, byte_idx_d;
  logic [7:0]       code_q, code_d;
  logic [7:0]       data_q, data_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             active_q, active_d;
  logic             done_q, done_d;

  logic             accept;
  logic             bit_end;
  logic [7:0]       cur_byte;

  assign accept  = req.send_request & ready_q;
  assign bit_end = (clk_cnt_q == CntMax);

  // State register; reset drives the line high asynchronously, aborting any frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= 1'b0;
      code_q     <= 8'h00;
      data_q     <= 8'h00;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      code_q     <= code_d;
      data_q     <= data_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    code_d     = code_q;
    data_d     = data_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          code_d     = req.response_code;
          data_d     = req.response_data;
          byte_idx_d = 1'b0;
          bit_idx_d  = '0;
          clk_cnt_d  = '0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = StData;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      StData: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          if (!byte_idx_q) begin
            // Second byte starts immediately, no idle gap between bytes.
            byte_idx_d = 1'b1;
            state_d    = StStart;
          end else begin
            byte_idx_d = 1'b0;
            state_d    = StIdle;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic, evaluated on next-state so outputs change with the state they describe.
  always_comb begin
    cur_byte = byte_idx_d ? data_d : code_d;
    tx_d     = 1'b1;
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = cur_byte[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
    ready_d  = (state_d == StIdle);
    active_d = (state_d != StIdle);
    done_d   = (state_q == StStop) && bit_end && byte_idx_q;
  end

  assign req.ready           = ready_q;
  assign tx_serial           = tx_q;
  assign transmission_active = active_q;
  assign tx_done             = done_q;

endmodule

// File: tb/tb_response_uart_tx.sv
// Scoreboard bench: stimulus queues expected bytes, a UART-decoding monitor pops and compares.
module tb_response_uart_tx;
  localparam int unsigned N  = 4;
  localparam int unsigned CW = 3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic tx_serial, transmission_active, tx_done;

  response_uart_tx_if rif ();

  response_uart_tx #(
    .CLKS_PER_BIT(N),
    .CNT_W       (CW)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .req                (rif),
    .tx_serial          (tx_serial),
    .transmission_active(transmission_active),
    .tx_done            (tx_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  bit mon_busy = 1'b0;
  int pos = 0;
  logic [7:0] acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 50)
        $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Monitor: decodes the line as 8N1 at mid-bit and checks frame-level timing.
  initial forever begin
    @(negedge clock);
    if (!reset_n) begin
      mon_busy = 1'b0;
    end else begin
      if (mon_busy) pos++;
      else if (tx_serial === 1'b0) begin
        mon_busy = 1'b1;
        pos = 0;
      end
      if (mon_busy && pos == 20 * N) begin
        chk("done_pulse", tx_done, 1);
        chk("done_ready", rif.ready, 1);
        chk("done_active", transmission_active, 0);
        chk("done_line", tx_serial, 1);
        mon_busy = 1'b0;
      end else if (mon_busy) begin
        chk("busy_ready", rif.ready, 0);
        chk("busy_active", transmission_active, 1);
        chk("busy_done", tx_done, 0);
        if (pos % N == N / 2) begin
          int bp;
          bp = (pos / N) % 10;
          if (bp == 0) chk("start_bit", tx_serial, 0);
          else if (bp < 9) acc[bp-1] = tx_serial;
          else begin
            chk("stop_bit", tx_serial, 1);
            if (exp_q.size() == 0) chk("unexpected_byte", acc, 32'hFFFF_FFFF);
            else chk("byte", acc, exp_q.pop_front());
          end
        end
      end else begin
        chk("idle_ready", rif.ready, 1);
        chk("idle_active", transmission_active, 0);
        chk("idle_done", tx_done, 0);
      end
    end
  end

  task automatic send(input logic [7:0] c, input logic [7:0] d, input bit hold);
    int t = 0;
    @(negedge clock);
    while (rif.ready !== 1'b1 && t < 40 * N) begin
      @(negedge clock);
      t++;
    end
    if (rif.ready !== 1'b1) begin
      chk("send_ready_timeout", t, 0);
      return;
    end
    rif.send_request  = 1'b1;
    rif.response_code = c;
    rif.response_data = d;
    @(posedge clock);
    exp_q.push_back(c);
    exp_q.push_back(d);
    #1;
    if (!hold) rif.send_request = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || mon_busy) && t < 25 * N + 20) begin
      @(posedge clock);
      t++;
    end
    chk("wait_idle_in_time", (t < 25 * N + 20), 1);
    repeat (3) @(posedge clock);
  endtask

  initial begin
    rif.send_request  = 1'b0;
    rif.response_code = 8'h00;
    rif.response_data = 8'h00;
    repeat (3) @(posedge clock);
    #2;
    chk("reset_line", tx_serial, 1);
    chk("reset_ready", rif.ready, 1);
    chk("reset_active", transmission_active, 0);
    chk("reset_done", tx_done, 0);
    reset_n = 1'b1;

    // Idle period: monitor checks idle outputs every cycle.
    repeat (1000) @(posedge clock);

    // Basic frame
    send(8'h0B, 8'h1A, 1'b0);
    wait_idle();

    // Busy rejection
    send(8'h1F, 8'h00, 1'b0);
    repeat (9) @(posedge clock);
    #1;
    rif.send_request  = 1'b1;
    rif.response_code = 8'hAA;
    rif.response_data = 8'h55;
    repeat (20) @(posedge clock);
    #1 rif.send_request = 1'b0;
    wait_idle();

    // Back-to-back with send_request held high
    send(8'hFF, 8'hFF, 1'b1);
    begin
      int t = 0;
      @(negedge clock);
      while (tx_done !== 1'b1 && t < 25 * N) begin
        @(negedge clock);
        t++;
      end
      chk("b2b_done_seen", tx_done, 1);
      rif.response_code = 8'h00;
      rif.response_data = 8'h00;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      @(posedge clock);
      #1 rif.send_request = 1'b0;
      @(negedge clock);
      chk("b2b_start_after_gap", tx_serial, 0);
    end
    wait_idle();

    // Reset during bit 3 of byte 1
    send(8'hA5, 8'h5A, 1'b0);
    repeat (14 * N + 1) @(posedge clock);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_line", tx_serial, 1);
    chk("abort_ready", rif.ready, 1);
    chk("abort_active", transmission_active, 0);
    chk("abort_done", tx_done, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    send(8'h07, 8'h19, 1'b0);
    wait_idle();

    // Inputs change every cycle after acceptance
    send(8'h3C, 8'hC3, 1'b0);
    repeat (25 * N) begin
      @(posedge clock);
      #1;
      rif.response_code = 8'($urandom);
      rif.response_data = 8'($urandom);
    end
    wait_idle();

    // Randomized frames with random busy-time pokes
    for (int i = 0; i < 8; i++) begin
      send(8'($urandom), 8'($urandom), 1'b0);
      if ($urandom_range(1, 0) == 1) begin
        repeat ($urandom_range(60, 2)) @(posedge clock);
        #1;
        rif.send_request  = 1'b1;
        rif.response_code = 8'($urandom);
        rif.response_data = 8'($urandom);
        repeat ($urandom_range(10, 1)) @(posedge clock);
        #1 rif.send_request = 1'b0;
      end
      wait_idle();
      repeat ($urandom_range(5, 0)) @(posedge clock);
    end

    chk("leftover_expected", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/response_uart_tx.md
Name: response_uart_tx

Overview:
- Transmit side of the PC command/response link; the command receiver decodes the 2-byte request (command code, sensor address).
- Accepts one 2-byte response (response code, then data/value byte) from the control FSM over a valid/ready handshake.
- Serializes both bytes back-to-back as UART 8N1, LSB first, on tx_serial toward the PC.
- Bit-timing generation, frame sequencing and completion signalling are all internal; no external uart_tx instance.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per UART bit (50 MHz / 9600 baud). Legal minimum 2.
- CNT_W, 13, width of bit-timing counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- send_request  input  1  valid; response bytes present this cycle.
- response_code  input  8  first byte sent (response/status code).
- response_data  input  8  second byte sent (measurement or status value).
- ready  output  1  high when idle and able to accept; request accepted on a clock edge where send_request and ready are both 1.
- tx_serial  output  1  UART line, idle high.
- transmission_active  output  1  high from the start bit of byte 0 through the stop bit of byte 1 inclusive.
- tx_done  output  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset (async assert, any state):
  - tx_serial=1, ready=1, transmission_active=0, tx_done=0.
  - State=IDLE; counters and byte index cleared; latched bytes cleared to 0x00.
  - Reset mid-frame aborts the frame immediately. The line goes high asynchronously, with no partial stop bit.
- States: IDLE, START, DATA, STOP.
  - byte_idx (0/1) selects the code or data shift register.
  - bit_idx (0..7) tracks the data bit.
  - clk_cnt (0..CLKS_PER_BIT-1) times each bit.
- IDLE:
  - ready=1, tx_serial=1.
  - On acceptance, latch response_code and response_data, set byte_idx=0, clk_cnt=0, go to START.
  - Inputs are not sampled again until the next acceptance; later changes do not affect the frame.
- START: tx_serial=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
- DATA:
  - tx_serial = current byte bit[bit_idx], each held CLKS_PER_BIT cycles, LSB first.
  - After bit 7, go to STOP.
- STOP:
  - tx_serial=1 for CLKS_PER_BIT cycles.
  - At the end of the stop bit with byte_idx=0: byte_idx=1, go directly to START. There is no inter-byte idle gap.
  - At the end of the stop bit with byte_idx=1: go to IDLE and pulse tx_done for 1 cycle.
- Timing:
  - tx_serial falls on the first rising edge after acceptance (1-cycle latency).
  - Full frame = 20*CLKS_PER_BIT cycles from that falling edge to tx_done.
  - ready=0 and transmission_active=1 throughout START/DATA/STOP.
  - In the tx_done cycle: ready=1, transmission_active=0.
- Handshake edges:
  - send_request while ready=0 is ignored, not queued.
  - send_request held high continuously: the next frame is accepted in the tx_done cycle; its start bit begins the following cycle (1 idle-high cycle between frames).
- All outputs are registered, so tx_serial is glitch-free.
- Counters wrap only under FSM control; clk_cnt never exceeds CLKS_PER_BIT-1.

Test Plan:
- Basic frame:
  - Stimulus: CLKS_PER_BIT=4; send code 0x0B, data 0x1A.
  - Required: tx_serial sampled mid-bit reads 0,1,1,0,1,0,0,0,0,1 then 0,0,1,0,1,1,0,0,0,1.
  - Required: tx_done pulses once, exactly 80 cycles after the first start-bit edge.
- Busy rejection:
  - Stimulus: send 0x1F/0x00, then at cycle 10 assert send_request with 0xAA/0x55.
  - Required: the line carries only 0x1F,0x00; no second frame; ready stays 0 until tx_done.
- Back-to-back:
  - Stimulus: hold send_request=1 with 0xFF/0xFF, then 0x00/0x00 presented from the tx_done cycle.
  - Required: the second frame is accepted in the tx_done cycle, its start bit follows after exactly 1 idle-high cycle, and it carries 0x00,0x00.
- Reset mid-frame:
  - Stimulus: assert reset_n=0 during bit 3 of byte 1.
  - Required: tx_serial=1 immediately (before the next clock edge), ready=1, transmission_active=0, no tx_done.
  - Required: after release, a new 0x07/0x19 frame transmits correctly.
- Input stability:
  - Stimulus: change response_code/response_data every cycle after acceptance of 0x3C/0xC3.
  - Required: the line carries 0x3C,0xC3.
- Idle:
  - Stimulus: no requests for 1000 cycles after reset.
  - Required: tx_serial=1, ready=1, transmission_active=0, tx_done=0 throughout.
